// File: rtl/ws2812_pkg.sv
// Shared types and 12 MHz timing defaults for the multi-string WS2812 driver.
// The brightness helper is only referenced when WS2812_BRIGHTNESS_EN is defined.
package ws2812_pkg;

    localparam int COLOR_BITS = 24;

    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_T0H_CYCLES   = 4;
    localparam int DEF_T1H_CYCLES   = 8;
    localparam int DEF_LATCH_CYCLES = 720;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_CAP,
        SEND,
        LATCH
    } state_t;

    // (b * (level + 1)) >> 8 keeps level=255 an exact identity.
    function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] level);
        logic [15:0] prod;
        prod = 16'(b) * (16'(level) + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_chan_shifter.sv
// One WS2812 string: 24-bit GRB shift register plus pulse-width encoding.
// With WS2812_BRIGHTNESS_EN defined, each colour byte is scaled at load time.
module ws2812_chan_shifter
    import ws2812_pkg::*;
#(
    parameter int CYC_W      = 4,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  send,
    input  logic [CYC_W-1:0]      cycle_cnt,
    input  logic [COLOR_BITS-1:0] pix,
    input  logic [7:0]            brightness,
    output logic                  dout
);

    localparam logic [CYC_W-1:0] T0H = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H = CYC_W'(T1H_CYCLES);

    logic [COLOR_BITS-1:0] sr;
    logic [COLOR_BITS-1:0] load_val;

`ifdef WS2812_BRIGHTNESS_EN
    assign load_val = {scale_byte(pix[23:16], brightness),
                       scale_byte(pix[15:8],  brightness),
                       scale_byte(pix[7:0],   brightness)};
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign load_val = pix;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_val;
        end else if (shift) begin
            sr <= {sr[COLOR_BITS-2:0], 1'b0};
        end
    end

    // The MSB selects the high time; the parent's cycle count paces all strings.
    assign dout = send && (cycle_cnt < (sr[COLOR_BITS-1] ? T1H : T0H));

endmodule

// File: rtl/ws2812_multi_driver.sv
// Lockstep WS2812 driver for NUM_CHANNELS strings fed from a 1-cycle-latency frame buffer.
// Optional macro WS2812_BRIGHTNESS_EN enables global brightness scaling in each channel.
module ws2812_multi_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_CHANNELS     = 4,
    parameter int LEDS_PER_CHANNEL = 64,
    parameter int BIT_CYCLES       = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES       = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES       = DEF_T1H_CYCLES,
    parameter int LATCH_CYCLES     = DEF_LATCH_CYCLES,
    localparam int ADDR_W = (LEDS_PER_CHANNEL > 1) ? $clog2(LEDS_PER_CHANNEL) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [7:0]                         brightness,
    output logic                               busy,
    output logic                               done,
    output logic                               pix_rd,
    output logic [ADDR_W-1:0]                  pix_addr,
    input  logic [COLOR_BITS*NUM_CHANNELS-1:0] pix_data,
    output logic [NUM_CHANNELS-1:0]            dout
);

    localparam int CYC_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LEDS_PER_CHANNEL - 1);
    localparam logic [4:0]        MSB_BIT  = 5'(COLOR_BITS - 1);

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  index;
    logic [4:0]         bit_cnt;
    logic [CYC_W-1:0]   cycle_cnt;
    logic [LAT_W-1:0]   latch_cnt;
    logic               bit_end;
    logic               last_pix;
    logic               load;
    logic               shift;
    logic               send;

    assign bit_end  = (cycle_cnt == CYC_LAST);
    assign last_pix = (index == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        pix_rd     = 1'b0;
        load       = 1'b0;
        send       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                pix_rd     = 1'b1;
                next_state = FETCH_CAP;
            end
            FETCH_CAP: begin
                load       = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                send = 1'b1;
                if (bit_end && (bit_cnt == 5'd0)) begin
                    next_state = last_pix ? LATCH : FETCH_REQ;
                end
            end
            LATCH: begin
                if (latch_cnt == LAT_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign shift    = send && bit_end;
    assign pix_addr = index;

    // Counters only advance in the states that own them; done marks the LATCH exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index     <= '0;
            bit_cnt   <= '0;
            cycle_cnt <= '0;
            latch_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == LATCH) && (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        index <= '0;
                    end
                end
                FETCH_CAP: begin
                    bit_cnt   <= MSB_BIT;
                    cycle_cnt <= '0;
                end
                SEND: begin
                    if (bit_end) begin
                        cycle_cnt <= '0;
                        if (bit_cnt == 5'd0) begin
                            latch_cnt <= '0;
                            if (!last_pix) begin
                                index <= index + ADDR_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CYC_W'(1);
                    end
                end
                LATCH: begin
                    latch_cnt <= latch_cnt + LAT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        ws2812_chan_shifter #(
            .CYC_W      (CYC_W),
            .T0H_CYCLES (T0H_CYCLES),
            .T1H_CYCLES (T1H_CYCLES)
        ) u_shifter (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .shift      (shift),
            .send       (send),
            .cycle_cnt  (cycle_cnt),
            .pix        (pix_data[COLOR_BITS*c +: COLOR_BITS]),
            .brightness (brightness),
            .dout       (dout[c])
        );
    end

endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Scoreboard bench for ws2812_multi_driver: 2 strings of 3 pixels, 20-cycle latch gap.
// Build with WS2812_BRIGHTNESS_EN to exercise the scaled-colour vectors.
module tb_ws2812_multi_driver;

    localparam int NCH       = 2;
    localparam int LEDS      = 3;
    localparam int BITC      = 15;
    localparam int T0H       = 4;
    localparam int T1H       = 8;
    localparam int LATCHC    = 20;
    localparam int AW        = 2;
    localparam int PIX_GAP   = 2 + 24 * BITC;
    localparam int FRAME_LEN = LEDS * PIX_GAP + LATCHC;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       brightness = 8'd255;
    logic             busy;
    logic             done;
    logic             pix_rd;
    logic [AW-1:0]    pix_addr;
    logic [24*NCH-1:0] pix_data = '0;
    logic [NCH-1:0]   dout;

    ws2812_multi_driver #(
        .NUM_CHANNELS     (NCH),
        .LEDS_PER_CHANNEL (LEDS),
        .BIT_CYCLES       (BITC),
        .T0H_CYCLES       (T0H),
        .T1H_CYCLES       (T1H),
        .LATCH_CYCLES     (LATCHC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .brightness (brightness),
        .busy       (busy),
        .done       (done),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    // Frame buffer model with one cycle of read latency.
    logic [23:0] mem0 [4];
    logic [23:0] mem1 [4];
    always @(posedge clk) begin
        if (pix_rd) begin
            pix_data <= {mem1[pix_addr], mem0[pix_addr]};
        end
    end

    int          exp_addr [$];
    logic [47:0] exp_word [$];
    int          exp_len  [$];

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int cyc = 0;
    int frame_cyc = 0;
    int last_rd = 0;
    bit prev_busy = 1'b0;
    int ea;
    int el;
    logic [47:0] ew;
    bit bitv;

    int          hi [NCH];
    int          last_rise [NCH];
    int          nbits [NCH];
    int          frame_bits [NCH];
    logic [23:0] acc [NCH];
    logic [23:0] word_out [NCH];
    bit          prev_d [NCH];
    bit          got [NCH];

    // Monitor: decodes the serial streams and pops expectations as events appear.
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                hi[c] = 0; nbits[c] = 0; frame_bits[c] = 0;
                prev_d[c] = 1'b0; got[c] = 1'b0; acc[c] = '0;
            end
        end else begin
            cyc++;
            if (busy && !prev_busy) frame_cyc = 0;
            else frame_cyc++;
            prev_busy = busy;

            if (pix_rd) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pix_rd_unexpected addr got=%0d", pix_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (pix_addr !== AW'(ea)) begin
                        errors++;
                        $display("[TB] FAIL pix_addr got=%0d expected=%0d", pix_addr, ea);
                    end
                    if (ea != 0) begin
                        checks++;
                        if (cyc - last_rd != PIX_GAP) begin
                            errors++;
                            $display("[TB] FAIL pix_rd_spacing got=%0d expected=%0d", cyc - last_rd, PIX_GAP);
                        end
                    end
                end
                last_rd = cyc;
            end

            if (done) begin
                done_seen++;
                checks++;
                if (exp_len.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL done_unexpected at cycle %0d", cyc);
                end else begin
                    el = exp_len.pop_front();
                    if (frame_cyc != el) begin
                        errors++;
                        $display("[TB] FAIL frame_len got=%0d expected=%0d", frame_cyc, el);
                    end
                end
                for (int c = 0; c < NCH; c++) frame_bits[c] = 0;
            end

            for (int c = 0; c < NCH; c++) begin
                if (dout[c] && !prev_d[c]) begin
                    if (frame_bits[c] > 0) begin
                        checks++;
                        if (cyc - last_rise[c] != ((nbits[c] == 0) ? BITC + 2 : BITC)) begin
                            errors++;
                            $display("[TB] FAIL bit_period ch%0d got=%0d expected=%0d", c,
                                     cyc - last_rise[c], (nbits[c] == 0) ? BITC + 2 : BITC);
                        end
                    end
                    last_rise[c] = cyc;
                end
                if (dout[c]) begin
                    hi[c]++;
                end else if (prev_d[c]) begin
                    checks++;
                    bitv = 1'b0;
                    if (hi[c] == T1H) bitv = 1'b1;
                    else if (hi[c] != T0H) begin
                        errors++;
                        $display("[TB] FAIL high_width ch%0d got=%0d expected=%0d_or_%0d", c, hi[c], T0H, T1H);
                    end
                    acc[c] = {acc[c][22:0], bitv};
                    nbits[c]++;
                    frame_bits[c]++;
                    if (nbits[c] == 24) begin
                        got[c] = 1'b1;
                        word_out[c] = acc[c];
                        nbits[c] = 0;
                    end
                    hi[c] = 0;
                end
                prev_d[c] = dout[c];
            end

            if (got[0] && got[1]) begin
                got[0] = 1'b0;
                got[1] = 1'b0;
                checks++;
                if (exp_word.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL word_unexpected got=%h_%h", word_out[1], word_out[0]);
                end else begin
                    ew = exp_word.pop_front();
                    if (word_out[0] !== ew[23:0]) begin
                        errors++;
                        $display("[TB] FAIL word_ch0 got=%h expected=%h", word_out[0], ew[23:0]);
                    end
                    checks++;
                    if (word_out[1] !== ew[47:24]) begin
                        errors++;
                        $display("[TB] FAIL word_ch1 got=%h expected=%h", word_out[1], ew[47:24]);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] a0, a1, a2, b0, b1, b2, input logic [7:0] level);
        mem0[0] = a0; mem0[1] = a1; mem0[2] = a2; mem0[3] = '0;
        mem1[0] = b0; mem1[1] = b1; mem1[2] = b2; mem1[3] = '0;
        brightness = level;
    endtask

    task automatic pushExpect(input logic [23:0] a0, a1, a2, b0, b1, b2);
        for (int i = 0; i < LEDS; i++) exp_addr.push_back(i);
        exp_word.push_back({b0, a0});
        exp_word.push_back({b1, a1});
        exp_word.push_back({b2, a2});
        exp_len.push_back(FRAME_LEN);
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (done_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", 32'(done_seen >= target), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_pix_rd", 32'(pix_rd), 32'd0);
        checkOutput("reset_pix_addr", 32'(pix_addr), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, with an extra start mid-SEND that must be ignored.
        applyStimulus(24'hA00000, 24'h5A5A5A, 24'h0F00F0, 24'h000001, 24'h123456, 24'hFFFFFF, 8'd255);
        pushExpect(24'hA00000, 24'h5A5A5A, 24'h0F00F0, 24'h000001, 24'h123456, 24'hFFFFFF);
        pulseStart();
        repeat (500) @(negedge clk);
        checkOutput("busy_mid_frame", 32'(busy), 32'd1);
        pulseStart();
        waitDone(1, 3000);
        repeat (40) @(negedge clk);
        checkOutput("no_queued_frame", 32'(done_seen), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Start held through done: back-to-back frames, busy low only in the done cycle.
        applyStimulus(24'h800001, 24'h000000, 24'hFFFFFF, 24'hC3C3C3, 24'h010101, 24'h7E0000, 8'd255);
        pushExpect(24'h800001, 24'h000000, 24'hFFFFFF, 24'hC3C3C3, 24'h010101, 24'h7E0000);
        pushExpect(24'h800001, 24'h000000, 24'hFFFFFF, 24'hC3C3C3, 24'h010101, 24'h7E0000);
        @(negedge clk) start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        checkOutput("b2b_done_seen", 32'(done), 32'd1);
        checkOutput("b2b_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("b2b_busy_after", 32'(busy), 32'd1);
        checkOutput("b2b_done_pulse", 32'(done), 32'd0);
        start = 1'b0;
        waitDone(3, 3000);
        repeat (5) @(negedge clk);

        // Reset during bit 10 of pixel 0 aborts the frame.
        pushExpect(24'h800001, 24'h000000, 24'hFFFFFF, 24'hC3C3C3, 24'h010101, 24'h7E0000);
        pulseStart();
        repeat (154) @(posedge clk);
        #1;
        checkOutput("abort_pre_dout", 32'(dout[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_dout", 32'(dout), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_pix_rd", 32'(pix_rd), 32'd0);
        exp_addr.delete();
        exp_word.delete();
        exp_len.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (1200) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_seen), 32'd3);
        pushExpect(24'h800001, 24'h000000, 24'hFFFFFF, 24'hC3C3C3, 24'h010101, 24'h7E0000);
        pulseStart();
        waitDone(4, 3000);

`ifdef WS2812_BRIGHTNESS_EN
        applyStimulus(24'hFF8002, 24'hFF8002, 24'hFF8002, 24'h0180FF, 24'h0180FF, 24'h0180FF, 8'd127);
        pushExpect(24'h7F4001, 24'h7F4001, 24'h7F4001, 24'h00407F, 24'h00407F, 24'h00407F);
        pulseStart();
        waitDone(5, 3000);
        applyStimulus(24'hFF8002, 24'hFF8002, 24'hFF8002, 24'h0180FF, 24'h0180FF, 24'h0180FF, 8'd0);
        pushExpect(24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
        pulseStart();
        waitDone(6, 3000);
`else
        applyStimulus(24'hFF8002, 24'hFF8002, 24'hFF8002, 24'h0180FF, 24'h0180FF, 24'h0180FF, 8'd0);
        pushExpect(24'hFF8002, 24'hFF8002, 24'hFF8002, 24'h0180FF, 24'h0180FF, 24'h0180FF);
        pulseStart();
        waitDone(5, 3000);
`endif

        repeat (10) @(negedge clk);
        checkOutput("leftover_addr", 32'(exp_addr.size()), 32'd0);
        checkOutput("leftover_words", 32'(exp_word.size()), 32'd0);
        checkOutput("leftover_done", 32'(exp_len.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
